// File: rtl/dmem_responder.sv
// Word-addressed data-memory target with fixed access latency: access at accept+WAIT_CYCLES, response registered.
// One request in flight; req_ready only in IDLE; response held stable until resp_ready.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int LANES = DATA_WIDTH / 8;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0] state;
  logic [3:0] waitCnt;

  logic                  capWe;
  logic [IDX_W-1:0]      capIdx;
  logic [DATA_WIDTH-1:0] capWdata;
  logic [LANES-1:0]      capBe;
  logic                  capErr;

  logic                  reqErr;
  logic                  doAccess;
  logic                  accWe;
  logic [IDX_W-1:0]      accIdx;
  logic [DATA_WIDTH-1:0] accWdata;
  logic [LANES-1:0]      accBe;
  logic                  accErr;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Misaligned, or any bit above the word index set, means the word does not exist.
  assign reqErr = (req_addr[1:0] != 2'b00) || ((req_addr >> (IDX_W + 2)) != '0);

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);

  // With no added latency the access uses the live request; otherwise the captured copy.
  always_comb begin
    accWe    = capWe;
    accIdx   = capIdx;
    accWdata = capWdata;
    accBe    = capBe;
    accErr   = capErr;
    doAccess = 1'b0;
    if (WAIT_CYCLES == 0) begin
      accWe    = req_we;
      accIdx   = req_addr[IDX_W+1:2];
      accWdata = req_wdata;
      accBe    = req_be;
      accErr   = reqErr;
      doAccess = rst && (state == ST_IDLE) && req_valid;
    end else begin
      doAccess = rst && (state == ST_WAIT) && (waitCnt == 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (doAccess && accWe && !accErr) begin
      for (int i = 0; i < LANES; i++) begin
        if (accBe[i]) mem[accIdx][8*i +: 8] <= accWdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      waitCnt    <= 4'd0;
      capWe      <= 1'b0;
      capIdx     <= '0;
      capWdata   <= '0;
      capBe      <= '0;
      capErr     <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            capWe    <= req_we;
            capIdx   <= req_addr[IDX_W+1:2];
            capWdata <= req_wdata;
            capBe    <= req_be;
            capErr   <= reqErr;
            waitCnt  <= WAIT_INIT;
            state    <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          waitCnt <= waitCnt - 4'd1;
          if (waitCnt == 4'd1) state <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (doAccess) begin
        resp_err   <= accErr;
        resp_rdata <= (accErr || accWe) ? '0 : mem[accIdx];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a 2-cycle instance driven by directed and random traffic, and a
// zero-wait instance with resp_ready tied high for back-to-back traffic.
module tb_dmem_responder;

  localparam int MEM_WORDS = 1024;
  localparam int WAITC     = 2;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [3:0]  req_be;

  logic        z_req_valid, z_req_ready, z_req_we, z_resp_valid, z_resp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_resp_rdata;
  logic [3:0]  z_req_be;

  int nAssert = 0;
  int nFail   = 0;

  // Reference memories: index 0 models the zero-wait instance, index 1 the 2-cycle one.
  logic [31:0] model [2][MEM_WORDS];

  logic [31:0] addr0 [8];
  logic [31:0] data0 [8];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(MEM_WORDS), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(MEM_WORDS), .WAIT_CYCLES(0)) dutZero (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we), .req_addr(z_req_addr),
    .req_wdata(z_req_wdata), .req_be(z_req_be),
    .resp_valid(z_resp_valid), .resp_ready(1'b1), .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAssert++;
    assert (observed === expected)
    else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural memory: an address names a word only if aligned and below MEM_WORDS*4 bytes.
  function automatic void refAccess(input int d, input logic we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] be,
                                    output logic [31:0] rd, output logic er);
    int unsigned w;
    er = (addr % 4 != 0) || (addr >= MEM_WORDS * 4);
    rd = 32'h0;
    if (!er) begin
      w = addr / 4;
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) model[d][w][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        rd = model[d][w];
      end
    end
  endfunction

  task automatic doReq(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, output logic [31:0] gotData);
    logic [31:0] expData;
    logic        expErr;
    int          lat;
    refAccess(1, we, addr, wdata, be, expData, expErr);
    check({tag, ".ready"}, req_ready, 1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    step();
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_addr = $urandom;
    req_wdata = $urandom; req_be = 4'($urandom_range(0, 15));
    lat = 0;
    while (!resp_valid && lat < 20) begin
      check({tag, ".busy"}, req_ready, 0);
      step();
      lat++;
    end
    check({tag, ".valid"}, resp_valid, 1);
    check({tag, ".lat"}, lat, WAITC);
    check({tag, ".rdata"}, resp_rdata, expData);
    check({tag, ".err"}, resp_err, expErr);
    gotData = resp_rdata;
    step();
    check({tag, ".done"}, resp_valid, 0);
  endtask

  // Zero-wait instance: request held valid, next request presented right after each accept.
  task automatic runZero(input logic we, input int n);
    logic [31:0] expQ [$];
    logic        errQ [$];
    logic [31:0] rd;
    logic        er;
    int acc = 0, got = 0, cyc = 0, lastT = -1;
    z_req_valid = 1'b1; z_req_we = we; z_req_addr = addr0[0]; z_req_wdata = data0[0]; z_req_be = 4'hF;
    while (got < n && cyc < 60) begin
      logic wasAcc;
      wasAcc = z_req_ready && z_req_valid;
      if (wasAcc) begin
        refAccess(0, we, addr0[acc], data0[acc], 4'hF, rd, er);
        expQ.push_back(rd);
        errQ.push_back(er);
      end
      step();
      cyc++;
      if (wasAcc) begin
        acc++;
        if (acc < n) begin
          z_req_addr = addr0[acc]; z_req_wdata = data0[acc];
        end else begin
          z_req_valid = 1'b0;
        end
      end
      if (z_resp_valid) begin
        if (expQ.size() > 0) begin
          check("zero.rdata", z_resp_rdata, expQ.pop_front());
          check("zero.err", z_resp_err, errQ.pop_front());
        end
        if (lastT >= 0) check("zero.spacing", cyc - lastT, 2);
        lastT = cyc;
        got++;
      end
    end
    check("zero.count", got, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] a;
    int kind;

    for (int i = 0; i < MEM_WORDS; i++) begin
      model[0][i] = 32'h0;
      model[1][i] = 32'h0;
    end
    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
    resp_ready = 1'b1;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 32'h0; z_req_wdata = 32'h0; z_req_be = 4'h0;
    step(); step();
    check("rst.req_ready", req_ready, 1);
    check("rst.resp_valid", resp_valid, 0);
    check("rst.resp_rdata", resp_rdata, 0);
    check("rst.resp_err", resp_err, 0);
    check("rst.zero_req_ready", z_req_ready, 1);
    check("rst.zero_resp_valid", z_resp_valid, 0);
    rst = 1'b1;
    step();

    // Put the words the bench touches into a known state.
    for (int i = 0; i < 64; i++) doReq("init", 1'b1, 32'(i * 4), 32'h0, 4'hF, d);

    doReq("st_deadbeef", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, d);
    doReq("ld_deadbeef", 1'b0, 32'h10, 32'h0, 4'h0, d);
    check("ld_deadbeef.const", d, 32'hDEADBEEF);

    doReq("st_lanes_full", 1'b1, 32'h20, 32'h11223344, 4'hF, d);
    doReq("st_lanes_part", 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, d);
    doReq("ld_lanes", 1'b0, 32'h20, 32'h0, 4'hF, d);
    check("ld_lanes.const", d, 32'h11BB33DD);
    doReq("st_be0", 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, d);
    doReq("ld_be0", 1'b0, 32'h20, 32'h0, 4'h0, d);
    check("ld_be0.const", d, 32'h11BB33DD);

    doReq("ld_misaligned", 1'b0, 32'h22, 32'h0, 4'hF, d);
    check("ld_misaligned.err", resp_err, 1);
    doReq("st_word0", 1'b1, 32'h0, 32'h5A5A1234, 4'hF, d);
    doReq("st_oor", 1'b1, 32'h1000, 32'h99999999, 4'hF, d);
    doReq("ld_word0", 1'b0, 32'h0, 32'h0, 4'h0, d);
    check("ld_word0.const", d, 32'h5A5A1234);

    // Response backpressure with a competing request that must be ignored.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0;
    step();
    req_addr = 32'h20;
    for (int i = 0; i < 20 && !resp_valid; i++) step();
    for (int i = 0; i < 5; i++) begin
      check("bp.valid", resp_valid, 1);
      check("bp.rdata", resp_rdata, 32'hDEADBEEF);
      check("bp.err", resp_err, 0);
      check("bp.req_ready", req_ready, 0);
      step();
    end
    resp_ready = 1'b1;
    step();
    check("bp.consumed", resp_valid, 0);
    check("bp.no_accept", req_ready, 1);
    req_valid = 1'b0;
    step();

    // Reset while a store waits: it must never reach the RAM.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    step();
    req_valid = 1'b0;
    check("rstmid.in_wait", req_ready, 0);
    step();
    rst = 1'b0;
    #1;
    check("rstmid.req_ready", req_ready, 1);
    check("rstmid.resp_valid", resp_valid, 0);
    check("rstmid.resp_rdata", resp_rdata, 0);
    check("rstmid.resp_err", resp_err, 0);
    step(); step();
    rst = 1'b1;
    step();
    doReq("ld_after_rst", 1'b0, 32'h30, 32'h0, 4'h0, d);
    check("ld_after_rst.const", d, 32'h0);

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
      else if (kind == 1) a = 32'h1000 + 32'($urandom_range(0, 4000) * 4);
      else                a = 32'($urandom_range(0, 63) * 4);
      doReq("rand", 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), d);
    end

    for (int i = 0; i < 7; i++) begin
      addr0[i] = 32'(i * 4);
      data0[i] = $urandom;
    end
    addr0[7] = 32'h1004;
    data0[7] = $urandom;
    runZero(1'b1, 8);
    runZero(1'b0, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RISC-V core: the target side of the memory stage's load/store path. Accepts one word-aligned load or store per valid/ready request handshake, waits a fixed number of cycles, performs the RAM access, and returns read data and an error flag over a valid/ready response handshake. It replaces the zero-latency combinational data RAM when a stall-capable memory stage is used.

## Interface
- `ADDR_WIDTH`, 32, request address width.
- `DATA_WIDTH`, 32, data word width; fixed at 32 (4 byte lanes).
- `MEM_WORDS`, 1024, number of 32-bit words; power of two.
- `WAIT_CYCLES`, 2, added access latency in cycles; range 0..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  32  store data.
- `req_be`  in  4  store byte enables; bit i writes `req_wdata[8i+7:8i]`.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  requester accepts response.
- `resp_rdata`  out  32  load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned or out-of-range request.

## Operation
- Word index = `req_addr[log2(MEM_WORDS)+1:2]`.
- Error if `req_addr[1:0] != 0` or any address bit above the word index is nonzero. An errored request performs no RAM access, returns `resp_rdata` = 0 and `resp_err` = 1.
- States:
  - IDLE: `req_ready` = 1. On `req_valid`, capture we/addr/wdata/be and the error flag, and load the wait counter with `WAIT_CYCLES`. Go to WAIT, or straight to ACCESS-and-RESP when `WAIT_CYCLES` = 0.
  - WAIT: `req_ready` = 0. Decrement the counter each cycle. At the edge where it reaches 0, perform the access and enter RESP.
  - RESP: `resp_valid` = 1, `req_ready` = 0. When `resp_ready` = 1, return to IDLE at that edge.
- Access:
  - Store: write only the enabled byte lanes. `be` = 0 is a legal no-op with no error.
  - Load: capture the full word into the `resp_rdata` register and ignore `be`.
- No request is accepted in the same cycle a response is consumed. `req_ready` rises in the cycle after the RESP→IDLE edge.
- RAM array is not reset. Simulation initializes all words to 0.

## Timing
- Reset values: state IDLE, `req_ready` = 1, `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0, counter = 0.
- Request accepted at edge E (`req_valid & req_ready` sampled high):
  - RAM write/read occurs at edge E+`WAIT_CYCLES`.
  - `resp_valid` is high from edge E+`WAIT_CYCLES` onward.
  - For `WAIT_CYCLES` = 0, the access happens at edge E itself and `resp_valid` is high in the next cycle.
- Minimum request-to-request spacing is `WAIT_CYCLES`+2 cycles.
- While `resp_valid` = 1 and `resp_ready` = 0, `resp_rdata` and `resp_err` hold stable.
- Inputs are ignored outside IDLE. Request fields need only be valid during the accept cycle.
- Reset asserted mid-operation:
  - Immediately return to reset values.
  - A store not yet committed (still in WAIT) is dropped.
  - A store already committed remains in RAM.
- A store followed by a load to the same address returns the new data; the write is complete before the load is accepted.

## Test plan
- After reset, `WAIT_CYCLES` = 2: store 0xDEADBEEF to 0x10 with be=0xF, then load 0x10 → load response 0xDEADBEEF, err=0; `resp_valid` rises exactly 2 edges after each accept.
- Byte lanes: store 0x11223344 to 0x20 with be=0xF, then 0xAABBCCDD with be=0x5, then load → 0x11BB33DD.
- Errors:
  - Load at 0x22 (misaligned) → err=1, rdata=0.
  - Store to 0x1000 with `MEM_WORDS` = 1024 (out of range) → err=1; a subsequent load at 0x0 still returns its prior value.
- Backpressure: hold `resp_ready` = 0 for 5 cycles after a load of 0x10 → `resp_valid`, rdata and err stay constant; `req_ready` = 0 throughout; one response is consumed when `resp_ready` rises.
- Reset mid-WAIT: accept a store of 0xCAFEF00D to 0x30, assert `rst` = 0 one cycle later → outputs go to reset values asynchronously; a subsequent load of 0x30 returns 0.
- `WAIT_CYCLES` = 0 build with `resp_ready` tied high: back-to-back loads → one response every 2 cycles with correct data.
